// File: rtl/ip_stream_format_pipe_in_pkg.sv
// Shared types for the IP stream formatter ingress: timestamp record, IPv4
// header field helpers, line-parser states and the data FIFO entry layout.
package tracker_pkg;
  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] nsec;
  } tracker_stats_struct;
endpackage

package packet_struct_pkg;
  localparam int IP_HDR_IHL_W   = 4;
  localparam int IP_HDR_MIN_IHL = 5;
endpackage

package ip_stream_format_pkg;
  import tracker_pkg::*;
  import packet_struct_pkg::*;

  localparam int IPF_DATA_WIDTH     = 256;
  localparam int IPF_DATA_BYTES     = IPF_DATA_WIDTH / 8;
  localparam int IPF_PADBYTES_WIDTH = $clog2(IPF_DATA_BYTES);
  localparam int IPF_HDR_BYTES_W    = 7;

  typedef enum logic [1:0] {
    HDR_FIRST  = 2'd0,
    HDR_SECOND = 2'd1,
    PASS_BODY  = 2'd2
  } ipf_state_e;

  typedef struct packed {
    logic [IPF_DATA_WIDTH-1:0]     data;
    logic                          last;
    logic [IPF_PADBYTES_WIDTH-1:0] padbytes;
    tracker_stats_struct           timestamp;
  } fifo_struct;

  // Undersized IHL is clamped only for masking; the line itself is never altered.
  function automatic logic [IPF_HDR_BYTES_W-1:0] ihl_to_hdr_bytes(
    input logic [IP_HDR_IHL_W-1:0] ihl
  );
    logic [IP_HDR_IHL_W-1:0] ihl_c;
    ihl_c = (ihl < IP_HDR_IHL_W'(IP_HDR_MIN_IHL)) ? IP_HDR_IHL_W'(IP_HDR_MIN_IHL) : ihl;
    return {1'b0, ihl_c, 2'b00};
  endfunction
endpackage

// File: rtl/ip_stream_format_pipe_in_if.sv
// Ingress line stream, data-FIFO write port and checksum request port of the
// formatter; slave is the formatter side, master the surrounding logic.
interface ip_stream_format_pipe_in_if #(
  parameter int DATA_WIDTH     = ip_stream_format_pkg::IPF_DATA_WIDTH,
  parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH / 8)
);
  import tracker_pkg::*;
  import ip_stream_format_pkg::*;

  logic                      src_ip_format_rx_val;
  logic                      ip_format_src_rx_rdy;
  logic [DATA_WIDTH-1:0]     src_ip_format_rx_data;
  logic                      src_ip_format_rx_last;
  logic [PADBYTES_WIDTH-1:0] src_ip_format_rx_padbytes;
  tracker_stats_struct       src_ip_format_rx_timestamp;

  logic                      ip_format_data_fifo_wr_req;
  logic                      data_fifo_ip_format_full;
  fifo_struct                ip_format_data_fifo_wr_data;

  logic                      ip_chksum_req_val;
  logic                      ip_chksum_req_rdy;
  logic [DATA_WIDTH-1:0]     ip_chksum_req_data;
  logic                      ip_chksum_req_last;

  modport master (
    output src_ip_format_rx_val, src_ip_format_rx_data, src_ip_format_rx_last,
           src_ip_format_rx_padbytes, src_ip_format_rx_timestamp,
           data_fifo_ip_format_full, ip_chksum_req_rdy,
    input  ip_format_src_rx_rdy, ip_format_data_fifo_wr_req, ip_format_data_fifo_wr_data,
           ip_chksum_req_val, ip_chksum_req_data, ip_chksum_req_last
  );

  modport slave (
    input  src_ip_format_rx_val, src_ip_format_rx_data, src_ip_format_rx_last,
           src_ip_format_rx_padbytes, src_ip_format_rx_timestamp,
           data_fifo_ip_format_full, ip_chksum_req_rdy,
    output ip_format_src_rx_rdy, ip_format_data_fifo_wr_req, ip_format_data_fifo_wr_data,
           ip_chksum_req_val, ip_chksum_req_data, ip_chksum_req_last
  );
endinterface

// File: rtl/ip_stream_format_pipe_in_hdr_mask.sv
// Combinational header byte-keep mask: byte i of header line k is kept iff
// i + k*DATA_BYTES < hdr_bytes. keep_o[0] corresponds to byte 0 of the line.
module ip_hdr_byte_mask #(
  parameter int DATA_BYTES  = 32,
  parameter int HDR_BYTES_W = 7
) (
  input  logic [HDR_BYTES_W-1:0] hdr_bytes_i,
  input  logic                   line_idx_i,
  output logic [DATA_BYTES-1:0]  keep_o
);
  logic [31:0] line_base;

  always_comb begin
    line_base = line_idx_i ? 32'(DATA_BYTES) : 32'd0;
    keep_o    = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_o[i] = (32'(i) + line_base) < 32'(hdr_bytes_i);
    end
  end
endmodule

// File: rtl/ip_stream_format_pipe_in.sv
// Ingress formatter: writes every accepted line to the data FIFO and a masked header copy to the
// checksum unit, both combinationally on accept (0 cycles); stalls unless every needed sink is ready.
module ip_stream_format_pipe_in
  import tracker_pkg::*;
  import packet_struct_pkg::*;
  import ip_stream_format_pkg::*;
#(
  parameter int DATA_WIDTH     = IPF_DATA_WIDTH,
  parameter int DATA_BYTES     = DATA_WIDTH / 8,
  parameter int PADBYTES_WIDTH = $clog2(DATA_BYTES)
) (
  input logic                       clk,
  input logic                       rst,
  ip_stream_format_pipe_in_if.slave bus
);
  ipf_state_e                 state_q, state_d;
  logic [IPF_HDR_BYTES_W-1:0] hdr_bytes_q, hdr_bytes_d;
  logic [IPF_HDR_BYTES_W-1:0] hdr_bytes_live, hdr_bytes_cur;
  tracker_stats_struct        ts_q, ts_d;
  logic                       in_hdr, spans_two, rx_rdy, accept;
  logic [DATA_BYTES-1:0]      keep;
  logic [DATA_WIDTH-1:0]      keep_bits;
  logic [PADBYTES_WIDTH-1:0]  padbytes;

  // IHL sits in the low nibble of byte 0, which occupies the top byte of the line.
  assign hdr_bytes_live = ihl_to_hdr_bytes(bus.src_ip_format_rx_data[DATA_WIDTH-5 -: IP_HDR_IHL_W]);
  assign spans_two      = 32'(hdr_bytes_live) > 32'(DATA_BYTES);
  assign hdr_bytes_cur  = (state_q == HDR_SECOND) ? hdr_bytes_q : hdr_bytes_live;
  assign padbytes       = bus.src_ip_format_rx_padbytes;

  ip_hdr_byte_mask #(
    .DATA_BYTES  (DATA_BYTES),
    .HDR_BYTES_W (IPF_HDR_BYTES_W)
  ) u_hdr_mask (
    .hdr_bytes_i (hdr_bytes_cur),
    .line_idx_i  (state_q == HDR_SECOND),
    .keep_o      (keep)
  );

  always_comb begin
    keep_bits = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_bits[DATA_WIDTH-1-8*i -: 8] = {8{keep[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR_FIRST;
      hdr_bytes_q <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      hdr_bytes_q <= hdr_bytes_d;
      ts_q        <= ts_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_bytes_d = hdr_bytes_q;
    ts_d        = ts_q;

    // Payload lines need only FIFO space; header lines also need the checksum unit.
    in_hdr = (state_q != PASS_BODY);
    rx_rdy = ~bus.data_fifo_ip_format_full & (bus.ip_chksum_req_rdy | ~in_hdr);
    accept = bus.src_ip_format_rx_val & rx_rdy;

    bus.ip_format_src_rx_rdy                  = rx_rdy;
    bus.ip_format_data_fifo_wr_req            = accept;
    bus.ip_format_data_fifo_wr_data.data      = bus.src_ip_format_rx_data;
    bus.ip_format_data_fifo_wr_data.last      = bus.src_ip_format_rx_last;
    bus.ip_format_data_fifo_wr_data.padbytes  = padbytes;
    bus.ip_format_data_fifo_wr_data.timestamp = (state_q == HDR_FIRST) ?
                                                bus.src_ip_format_rx_timestamp : ts_q;

    bus.ip_chksum_req_val  = accept & in_hdr;
    bus.ip_chksum_req_data = bus.src_ip_format_rx_data & keep_bits;
    // A truncating last also closes the request so exactly one response is owed per packet.
    bus.ip_chksum_req_last = in_hdr & (bus.src_ip_format_rx_last |
                                       (state_q == HDR_SECOND) | ~spans_two);

    if (accept) begin
      unique case (state_q)
        HDR_FIRST: begin
          hdr_bytes_d = hdr_bytes_live;
          ts_d        = bus.src_ip_format_rx_timestamp;
          if (!bus.src_ip_format_rx_last) state_d = spans_two ? HDR_SECOND : PASS_BODY;
        end
        HDR_SECOND: state_d = bus.src_ip_format_rx_last ? HDR_FIRST : PASS_BODY;
        PASS_BODY:  if (bus.src_ip_format_rx_last) state_d = HDR_FIRST;
        default:    state_d = HDR_FIRST;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_stream_format_pipe_in.sv
// Self-checking bench for ip_stream_format_pipe_in: packet-level reference
// model, per-cycle compare on the falling edge, directed and random traffic.
module tb_ip_stream_format_pipe_in;
  import tracker_pkg::*;
  import ip_stream_format_pkg::*;

  localparam int DW = 256;
  localparam int DB = 32;
  localparam int M_READY   = 0;
  localparam int M_RAND    = 1;
  localparam int M_CHKLOW  = 2;
  localparam int M_PAYSTALL = 3;

  typedef struct {
    logic [DW-1:0]       data;
    logic                last;
    logic [4:0]          pad;
    tracker_stats_struct ts_in;
    tracker_stats_struct ts_exp;
    int                  idx;
    int                  hdr_bytes;
    int                  hdr_lines;
  } line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ip_stream_format_pipe_in_if #(.DATA_WIDTH(DW)) bus ();

  ip_stream_format_pipe_in #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  line_t lines[$];
  line_t cur;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    n_wr = 0;
  int    n_chk = 0;
  logic  acc_seen = 1'b0;
  logic [DW-1:0] cap_chk_data[$];
  logic          cap_chk_last[$];
  logic [63:0]   cap_ts[$];
  logic [4:0]    cap_pad[$];
  logic          cap_last[$];

  logic          cmp_in_hdr, cmp_rdy, cmp_last;
  logic [DW-1:0] cmp_chk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Expected behaviour derived from the presented line's place in its packet.
  always @(negedge clk) begin
    acc_seen = 1'b0;
    if (rst) begin
      check("rst_wr_req", DW'(bus.ip_format_data_fifo_wr_req), DW'(0));
      check("rst_chk_val", DW'(bus.ip_chksum_req_val), DW'(0));
    end else if (bus.src_ip_format_rx_val) begin
      cmp_in_hdr = cur.idx < cur.hdr_lines;
      cmp_rdy = !bus.data_fifo_ip_format_full && (bus.ip_chksum_req_rdy || !cmp_in_hdr);
      check("rx_rdy", DW'(bus.ip_format_src_rx_rdy), DW'(cmp_rdy));
      check("wr_req", DW'(bus.ip_format_data_fifo_wr_req), DW'(cmp_rdy));
      check("chk_val", DW'(bus.ip_chksum_req_val), DW'(cmp_rdy && cmp_in_hdr));
      if (cmp_rdy && bus.ip_format_data_fifo_wr_req) begin
        check("fifo_data", bus.ip_format_data_fifo_wr_data.data, cur.data);
        check("fifo_last", DW'(bus.ip_format_data_fifo_wr_data.last), DW'(cur.last));
        check("fifo_pad", DW'(bus.ip_format_data_fifo_wr_data.padbytes), DW'(cur.pad));
        check("fifo_ts", DW'({bus.ip_format_data_fifo_wr_data.timestamp}), DW'({cur.ts_exp}));
        n_wr++;
        cap_ts.push_back({bus.ip_format_data_fifo_wr_data.timestamp});
        cap_pad.push_back(bus.ip_format_data_fifo_wr_data.padbytes);
        cap_last.push_back(bus.ip_format_data_fifo_wr_data.last);
        if (cmp_in_hdr && bus.ip_chksum_req_val) begin
          cmp_chk = '0;
          for (int b = 0; b < DB; b++) begin
            if (b + cur.idx * DB < cur.hdr_bytes) cmp_chk[DW-1-8*b -: 8] = cur.data[DW-1-8*b -: 8];
          end
          cmp_last = cur.last || (cur.idx == cur.hdr_lines - 1);
          check("chk_data", bus.ip_chksum_req_data, cmp_chk);
          check("chk_last", DW'(bus.ip_chksum_req_last), DW'(cmp_last));
          n_chk++;
          cap_chk_data.push_back(bus.ip_chksum_req_data);
          cap_chk_last.push_back(bus.ip_chksum_req_last);
        end
      end
      acc_seen = bus.src_ip_format_rx_val && bus.ip_format_src_rx_rdy;
    end else begin
      check("idle_wr_req", DW'(bus.ip_format_data_fifo_wr_req), DW'(0));
      check("idle_chk_val", DW'(bus.ip_chksum_req_val), DW'(0));
    end
  end

  task automatic add_pkt(input int ihl, input int nlines, input int pad);
    tracker_stats_struct ts;
    line_t l;
    int hb;
    ts = {$urandom, $urandom};
    hb = ((ihl < 5) ? 5 : ihl) * 4;
    for (int i = 0; i < nlines; i++) begin
      for (int w = 0; w < DW / 32; w++) l.data[w*32 +: 32] = $urandom;
      if (i == 0) l.data[DW-1 -: 8] = {4'h4, 4'(ihl)};
      l.last      = (i == nlines - 1);
      l.pad       = l.last ? 5'(pad) : 5'($urandom_range(0, 31));
      l.ts_exp    = ts;
      l.ts_in     = (i == 0) ? ts : {$urandom, $urandom};
      l.idx       = i;
      l.hdr_bytes = hb;
      l.hdr_lines = (hb > DB) ? 2 : 1;
      lines.push_back(l);
    end
  endtask

  task automatic clear_caps();
    cap_chk_data.delete();
    cap_chk_last.delete();
    cap_ts.delete();
    cap_pad.delete();
    cap_last.delete();
  endtask

  task automatic run_q(input int mode, input int hold, input int budget,
                       input bit allow_partial, output int cycles);
    cycles = 0;
    while (lines.size() > 0 && cycles < budget) begin
      cur = lines[0];
      bus.src_ip_format_rx_data      = cur.data;
      bus.src_ip_format_rx_last      = cur.last;
      bus.src_ip_format_rx_padbytes  = cur.pad;
      bus.src_ip_format_rx_timestamp = cur.ts_in;
      bus.src_ip_format_rx_val       = (mode == M_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        M_RAND: begin
          bus.data_fifo_ip_format_full = ($urandom_range(0, 3) == 0);
          bus.ip_chksum_req_rdy        = ($urandom_range(0, 2) != 0);
        end
        M_CHKLOW: begin
          bus.data_fifo_ip_format_full = 1'b0;
          bus.ip_chksum_req_rdy        = (cycles >= hold);
        end
        M_PAYSTALL: begin
          bus.data_fifo_ip_format_full = (cycles >= 1 && cycles < 1 + hold);
          bus.ip_chksum_req_rdy        = (cur.idx < cur.hdr_lines);
        end
        default: begin
          bus.data_fifo_ip_format_full = 1'b0;
          bus.ip_chksum_req_rdy        = 1'b1;
        end
      endcase
      @(posedge clk);
      #1;
      if (acc_seen) void'(lines.pop_front());
      cycles++;
    end
    bus.src_ip_format_rx_val     = 1'b0;
    bus.data_fifo_ip_format_full = 1'b0;
    bus.ip_chksum_req_rdy        = 1'b1;
    if (!allow_partial) check("run_budget_lines_left", DW'(lines.size()), DW'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bw, bc, nl;
    logic [DW-1:0] l0, l1, v;
    logic [63:0] tsx;

    rst = 1'b1;
    bus.src_ip_format_rx_val       = 1'b0;
    bus.src_ip_format_rx_data      = '0;
    bus.src_ip_format_rx_last      = 1'b0;
    bus.src_ip_format_rx_padbytes  = '0;
    bus.src_ip_format_rx_timestamp = '0;
    bus.data_fifo_ip_format_full   = 1'b0;
    bus.ip_chksum_req_rdy          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 20-byte header, 3 lines, all sinks ready.
    clear_caps(); bw = n_wr; bc = n_chk;
    add_pkt(5, 3, 0); l0 = lines[0].data;
    run_q(M_READY, 0, 20, 1'b0, cyc);
    check("t1_cycles", DW'(cyc), DW'(3));
    check("t1_wr_count", DW'(n_wr - bw), DW'(3));
    check("t1_chk_count", DW'(n_chk - bc), DW'(1));
    if (cap_chk_data.size() > 0) begin
      v = cap_chk_data[0];
      check("t1_chk_tail_zero", DW'(v[95:0]), DW'(0));
      check("t1_chk_head", DW'(v[255:96]), DW'(l0[255:96]));
      check("t1_chk_last", DW'(cap_chk_last[0]), DW'(1));
    end

    // IHL 15, 4 lines: two checksum lines, first-line timestamp everywhere.
    clear_caps(); bw = n_wr; bc = n_chk;
    add_pkt(15, 4, 3); l0 = lines[0].data; l1 = lines[1].data; tsx = {lines[0].ts_in};
    run_q(M_READY, 0, 20, 1'b0, cyc);
    check("t2_wr_count", DW'(n_wr - bw), DW'(4));
    check("t2_chk_count", DW'(n_chk - bc), DW'(2));
    if (cap_chk_data.size() == 2) begin
      check("t2_chk0_full", cap_chk_data[0], l0);
      check("t2_chk0_last", DW'(cap_chk_last[0]), DW'(0));
      v = cap_chk_data[1];
      check("t2_chk1_tail_zero", DW'(v[31:0]), DW'(0));
      check("t2_chk1_head", DW'(v[255:32]), DW'(l1[255:32]));
      check("t2_chk1_last", DW'(cap_chk_last[1]), DW'(1));
    end
    foreach (cap_ts[i]) check("t2_ts", DW'(cap_ts[i]), DW'(tsx));

    // Single-line packet with padbytes 10.
    clear_caps(); bw = n_wr; bc = n_chk;
    add_pkt(5, 1, 10);
    run_q(M_READY, 0, 20, 1'b0, cyc);
    check("t3_wr_count", DW'(n_wr - bw), DW'(1));
    check("t3_chk_count", DW'(n_chk - bc), DW'(1));
    if (cap_pad.size() > 0) begin
      check("t3_pad", DW'(cap_pad[0]), DW'(10));
      check("t3_last", DW'(cap_last[0]), DW'(1));
    end
    if (cap_chk_last.size() > 0) check("t3_chk_last", DW'(cap_chk_last[0]), DW'(1));

    // Checksum unit not ready for 5 cycles on the first line.
    clear_caps(); bw = n_wr; bc = n_chk;
    add_pkt(5, 2, 0);
    run_q(M_CHKLOW, 5, 30, 1'b0, cyc);
    check("t4_cycles", DW'(cyc), DW'(7));
    check("t4_wr_count", DW'(n_wr - bw), DW'(2));
    check("t4_chk_count", DW'(n_chk - bc), DW'(1));

    // FIFO full during payload with checksum unit not ready.
    clear_caps(); bw = n_wr; bc = n_chk;
    add_pkt(5, 3, 0);
    run_q(M_PAYSTALL, 4, 30, 1'b0, cyc);
    check("t5_cycles", DW'(cyc), DW'(7));
    check("t5_wr_count", DW'(n_wr - bw), DW'(3));
    check("t5_chk_count", DW'(n_chk - bc), DW'(1));

    // IHL 15 truncated by last on line 0.
    clear_caps(); bc = n_chk;
    add_pkt(15, 1, 0);
    run_q(M_READY, 0, 20, 1'b0, cyc);
    check("t6_chk_count", DW'(n_chk - bc), DW'(1));
    if (cap_chk_last.size() > 0) check("t6_chk_last", DW'(cap_chk_last[0]), DW'(1));

    // Reset in the middle of a packet, then a fresh header.
    add_pkt(15, 4, 0);
    run_q(M_READY, 0, 2, 1'b1, cyc);
    check("t6_partial_left", DW'(lines.size()), DW'(2));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lines.delete();
    clear_caps(); bc = n_chk;
    add_pkt(5, 2, 0);
    run_q(M_READY, 0, 20, 1'b0, cyc);
    check("t6_post_rst_chk_count", DW'(n_chk - bc), DW'(1));
    if (cap_chk_data.size() > 0) begin
      v = cap_chk_data[0];
      check("t6_post_rst_byte0", DW'(v[255:248]), DW'(8'h45));
      check("t6_post_rst_last", DW'(cap_chk_last[0]), DW'(1));
    end

    // Randomized traffic and back-pressure.
    for (int p = 0; p < 80; p++) begin
      clear_caps(); bw = n_wr;
      nl = $urandom_range(1, 5);
      add_pkt($urandom_range(0, 15), nl, $urandom_range(0, 31));
      run_q((p % 5 == 0) ? M_READY : M_RAND, 0, 300, 1'b0, cyc);
      check("rand_wr_count", DW'(n_wr - bw), DW'(nl));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
